debug_controller: RTL

Run-control and register-access sequencer for the single-cycle RISC-V core's coprocessor IO port. Accepts commands from a host-side debug transport over a valid/ready handshake and drives `coprocessorIOControl`, `coprocessorIOAddr` and `coprocessorIODataOut` into the datapath. It halts, resumes and single-steps the core, and reads or writes GPRs and CSRs while halted. It sits between the debug transport and the datapath, beside the control unit.

---
 rtl/debug_controller.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/debug_controller.sv
// debug_controller: run-control and GPR/CSR access sequencer driving the core's coprocessor IO port
module debug_controller #(
    parameter int N = 64,
    parameter bit HALT_ON_RESET = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [14:0]  cmd_addr,
    input  logic [N-1:0] cmd_data,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_data,
    output logic         rsp_err,
    input  logic [1:0]   breakSrc,
    output logic [4:0]   coprocessorIOControl,
    output logic [14:0]  coprocessorIOAddr,
    output logic [N-1:0] coprocessorIODataOut,
    input  logic [N-1:0] coprocessorIODataIn
);
    typedef enum logic [2:0] {S_RUN, S_HALTED, S_RD_SETUP, S_RD_CAP, S_WR, S_STEP, S_RESP} state_t;
    localparam logic [2:0] OP_STATUS = 3'd0;
    localparam logic [2:0] OP_HALT = 3'd1;
    localparam logic [2:0] OP_RESUME = 3'd2;
    localparam logic [2:0] OP_STEP = 3'd3;
    localparam logic [4:0] CTRL_HALT = 5'b00100;
    state_t r_state, w_state;
    logic r_halted, w_halted;
    logic [2:0] r_cause, w_cause;
    logic [15:0] r_step_count, w_step_count, r_step_tgt, w_step_tgt;
    logic [4:0] w_ctrl;
    logic [14:0] w_addr;
    logic [N-1:0] w_dout, w_rsp_data;
    logic w_rsp_valid, w_rsp_err, w_acc, w_bad, w_brk;
    assign w_acc = cmd_valid && cmd_ready;
    assign w_brk = breakSrc != 2'b00;
    // access is illegal while running or with address bits beyond the GPR/CSR space
    assign w_bad = !r_halted || (cmd_op[1] ? cmd_addr[14:12] != 3'b000 : cmd_addr[14:5] != 10'b0);
    // next state, flags and the registered output values
    always_comb begin
        w_state = r_state;
        w_halted = r_halted;
        w_cause = r_cause;
        w_step_count = r_step_count;
        w_step_tgt = r_step_tgt;
        w_addr = coprocessorIOAddr;
        w_dout = coprocessorIODataOut;
        w_rsp_valid = rsp_valid;
        w_rsp_err = rsp_err;
        w_rsp_data = rsp_data;
        case (r_state)
            S_RUN, S_HALTED: begin
                if (w_acc) begin
                    w_state = S_RESP;
                    w_rsp_valid = 1'b1;
                    w_rsp_err = 1'b0;
                    w_rsp_data = '0;
                    case (cmd_op)
                        OP_STATUS: w_rsp_data = N'({r_step_count, r_cause, r_halted});
                        OP_HALT: begin
                            if (!r_halted) begin
                                w_halted = 1'b1;
                                w_cause = 3'b001;
                            end
                        end
                        OP_RESUME: w_halted = 1'b0;
                        OP_STEP: begin
                            if (r_halted && cmd_data[15:0] != 16'd0) begin
                                w_state = S_STEP;
                                w_rsp_valid = 1'b0;
                                w_step_tgt = cmd_data[15:0];
                                w_step_count = 16'd0;
                            end else begin
                                w_rsp_err = 1'b1;
                            end
                        end
                        default: begin
                            if (w_bad) begin
                                w_rsp_err = 1'b1;
                            end else begin
                                w_state = cmd_op[0] ? S_WR : S_RD_SETUP;
                                w_rsp_valid = 1'b0;
                                w_addr = cmd_addr;
                                w_dout = cmd_op[0] ? cmd_data : coprocessorIODataOut;
                            end
                        end
                    endcase
                end else if (r_state == S_RUN && w_brk) begin
                    w_state = S_HALTED;
                    w_halted = 1'b1;
                    w_cause = {breakSrc, 1'b0};
                end
            end
            S_RD_SETUP: w_state = S_RD_CAP;
            S_RD_CAP: begin
                w_state = S_RESP;
                w_rsp_valid = 1'b1;
                w_rsp_err = 1'b0;
                w_rsp_data = coprocessorIODataIn;
            end
            S_WR: begin
                w_state = S_RESP;
                w_rsp_valid = 1'b1;
                w_rsp_err = 1'b0;
                w_rsp_data = '0;
            end
            S_STEP: begin
                w_step_count = r_step_count + 16'd1;
                if (w_step_count == r_step_tgt || w_brk) begin
                    w_state = S_RESP;
                    w_rsp_valid = 1'b1;
                    w_rsp_err = 1'b0;
                    w_rsp_data = N'(w_step_count);
                    w_cause = w_brk ? {breakSrc, 1'b0} : r_cause;
                end
            end
            default: begin
                if (rsp_ready) begin
                    w_state = r_halted ? S_HALTED : S_RUN;
                    w_rsp_valid = 1'b0;
                end
            end
        endcase
        w_ctrl = (w_state == S_RD_CAP) ? coprocessorIOControl :
                 (w_state == S_RD_SETUP || w_state == S_WR) ? {1'b0, cmd_op[1], 1'b1, ~cmd_op[0], cmd_op[0]} :
                 (w_state == S_HALTED || (w_state == S_RESP && w_halted)) ? CTRL_HALT : 5'b00000;
    end
    // state and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= HALT_ON_RESET ? S_HALTED : S_RUN;
            r_halted <= HALT_ON_RESET;
            r_cause <= HALT_ON_RESET ? 3'b001 : 3'b000;
            r_step_count <= 16'd0;
            r_step_tgt <= 16'd0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err <= 1'b0;
            rsp_data <= '0;
            coprocessorIOControl <= HALT_ON_RESET ? CTRL_HALT : 5'b00000;
            coprocessorIOAddr <= 15'd0;
            coprocessorIODataOut <= '0;
        end else begin
            r_state <= w_state;
            r_halted <= w_halted;
            r_cause <= w_cause;
            r_step_count <= w_step_count;
            r_step_tgt <= w_step_tgt;
            cmd_ready <= (w_state == S_RUN || w_state == S_HALTED);
            rsp_valid <= w_rsp_valid;
            rsp_err <= w_rsp_err;
            rsp_data <= w_rsp_data;
            coprocessorIOControl <= w_ctrl;
            coprocessorIOAddr <= w_addr;
            coprocessorIODataOut <= w_dout;
        end
    end
endmodule
